// File: rtl/buffer_read_sequencer_pkg.sv
// Shared types and defaults for the buffer read sequencer: FSM encoding, mode values, parameter defaults.
package buffer_read_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_SERIAL   = 1'b0;
  localparam logic MODE_PARALLEL = 1'b1;

  localparam int DEF_ARRAY_SIZE = 9;
  localparam int DEF_ADDR_W     = 14;
  localparam int DEF_RD_LATENCY = 2;

  function automatic int unsigned popcount32(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n = n + {31'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/buffer_read_sequencer_rd_valid_pipe.sv
// Delays the issue strobe and its bank index by LAT cycles to line up with RAM data on bus1/bus2.
// No back-pressure: every entry shifts each cycle; clr_i drops everything in flight.
module rd_valid_pipe #(
  parameter int LAT    = 2,
  parameter int BANK_W = 4
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              vld_i,
  input  logic [BANK_W-1:0] bank_i,
  output logic              vld_o,
  output logic [BANK_W-1:0] bank_o,
  output logic              pending_o
);

  logic [LAT-1:0]    vld_q;
  logic [BANK_W-1:0] bank_q [LAT];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) bank_q[i] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      bank_q[0] <= bank_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        bank_q[i] <= bank_q[i-1];
      end
    end
  end

  // Beats still travelling that have not yet reached the output stage.
  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i < LAT - 1; i++) pending_o = pending_o | vld_q[i];
  end

  assign vld_o  = vld_q[LAT-1];
  assign bank_o = bank_q[LAT-1];

endmodule

// File: rtl/buffer_read_sequencer.sv
// Read-side sequencer for the buffer RAM array: serial per-bank (bus1) or full-width (bus2) reads.
// enb/addrb registered, rd_valid RD_LATENCY cycles after enb; pause holds issue, in-flight beats complete.
module buffer_read_sequencer
  import buffer_read_sequencer_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                          r_clk_i,
  input  logic                          reset_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [ADDR_W-1:0]             cmd_base_i,
  input  logic [ADDR_W-1:0]             cmd_len_i,
  input  logic                          cmd_mode_i,
  input  logic [ARRAY_SIZE-1:0]         cmd_mask_i,
  input  logic                          pause_i,
  output logic [ARRAY_SIZE-1:0]         enb_o,
  output logic [ADDR_W-1:0]             addrb_o,
  output logic                          output_sel_o,
  output logic                          rd_valid_o,
  output logic [$clog2(ARRAY_SIZE)-1:0] rd_bank_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int BANK_W = $clog2(ARRAY_SIZE);
  localparam int BEAT_W = ADDR_W + BANK_W + 1;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     addrb_q, addrb_d;
  logic [BEAT_W-1:0]     beats_q, beats_d;
  logic [ARRAY_SIZE-1:0] mask_q, mask_d;
  logic [ARRAY_SIZE-1:0] enb_q, enb_d;
  logic                  mode_q, mode_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [BANK_W-1:0]     iss_bank_q, iss_bank_d;

  logic [BANK_W-1:0]     first_bank, cmd_first_bank, nxt_bank;
  logic                  nxt_found;
  logic                  accept;
  logic                  pipe_pending;

  assign accept = cmd_valid_i && (state_q == ST_IDLE);

  // Descending scan so the last hit is the lowest qualifying bank.
  always_comb begin
    first_bank     = '0;
    cmd_first_bank = '0;
    nxt_bank       = '0;
    nxt_found      = 1'b0;
    for (int i = ARRAY_SIZE - 1; i >= 0; i--) begin
      if (mask_q[i]) first_bank = BANK_W'(i);
      if (cmd_mask_i[i]) cmd_first_bank = BANK_W'(i);
      if (mask_q[i] && (i > int'(bank_q))) begin
        nxt_found = 1'b1;
        nxt_bank  = BANK_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    addrb_d    = addrb_q;
    beats_d    = beats_q;
    mask_d     = mask_q;
    mode_d     = mode_q;
    bank_d     = bank_q;
    enb_d      = '0;
    iss_bank_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = cmd_base_i;
          mask_d = cmd_mask_i;
          mode_d = cmd_mode_i;
          bank_d = cmd_first_bank;
          if (cmd_mode_i == MODE_PARALLEL) beats_d = BEAT_W'(cmd_len_i);
          else beats_d = BEAT_W'(cmd_len_i) * BEAT_W'(popcount32(32'(cmd_mask_i)));
          if ((cmd_len_i == '0) || (cmd_mask_i == '0)) state_d = ST_DONE;
          else state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!pause_i) begin
          addrb_d = addr_q;
          beats_d = beats_q - BEAT_W'(1);
          if (mode_q == MODE_PARALLEL) begin
            enb_d  = mask_q;
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            enb_d      = ARRAY_SIZE'(1) << bank_q;
            iss_bank_d = bank_q;
            if (nxt_found) begin
              bank_d = nxt_bank;
            end else begin
              bank_d = first_bank;
              addr_d = addr_q + ADDR_W'(1);
            end
          end
          if (beats_q == BEAT_W'(1)) state_d = ST_DRAIN;
        end
      end
      // Leave once only the final pipe stage may still hold a beat, so done follows it directly.
      ST_DRAIN: if ((enb_q == '0) && !pipe_pending) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge r_clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      addrb_q    <= '0;
      beats_q    <= '0;
      mask_q     <= '0;
      enb_q      <= '0;
      mode_q     <= 1'b0;
      bank_q     <= '0;
      iss_bank_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      addrb_q    <= addrb_d;
      beats_q    <= beats_d;
      mask_q     <= mask_d;
      enb_q      <= enb_d;
      mode_q     <= mode_d;
      bank_q     <= bank_d;
      iss_bank_q <= iss_bank_d;
    end
  end

  rd_valid_pipe #(
    .LAT    (RD_LATENCY),
    .BANK_W (BANK_W)
  ) u_rd_valid_pipe (
    .clk_i     (r_clk_i),
    .clr_i     (reset_i),
    .vld_i     (|enb_q),
    .bank_i    (iss_bank_q),
    .vld_o     (rd_valid_o),
    .bank_o    (rd_bank_o),
    .pending_o (pipe_pending)
  );

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign enb_o        = enb_q;
  assign addrb_o      = addrb_q;
  assign output_sel_o = mode_q;

endmodule

// File: tb/tb_buffer_read_sequencer.sv
// Directed bench for buffer_read_sequencer: parallel, serial, wrap, empty, pause and mid-command reset.
module tb_buffer_read_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [13:0] cmd_base;
  logic [13:0] cmd_len;
  logic        cmd_mode;
  logic [8:0]  cmd_mask;
  logic        pause;
  logic [8:0]  enb;
  logic [13:0] addrb;
  logic        output_sel;
  logic        rd_valid;
  logic [3:0]  rd_bank;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [8:0]  e_enb  [$];
  logic [13:0] e_addr [$];
  int          e_cyc  [$];
  logic [3:0]  v_bank [$];
  int          v_cyc  [$];
  int          done_n, done_cyc, ready_busy, ready_after, sel1;

  always #5 clk = ~clk;

  buffer_read_sequencer dut (
    .r_clk_i      (clk),
    .reset_i      (reset),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_base_i   (cmd_base),
    .cmd_len_i    (cmd_len),
    .cmd_mode_i   (cmd_mode),
    .cmd_mask_i   (cmd_mask),
    .pause_i      (pause),
    .enb_o        (enb),
    .addrb_o      (addrb),
    .output_sel_o (output_sel),
    .rd_valid_o   (rd_valid),
    .rd_bank_o    (rd_bank),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Offers one command and records every enb beat and rd_valid beat with its cycle number
  // (cycle 1 = first cycle after the accepting edge). Pause is high for cycles [p_start, p_start+p_len).
  task automatic run_cmd(input logic [13:0] base, input logic [13:0] len, input logic mode,
                         input logic [8:0] mask, input int p_start, input int p_len);
    e_enb.delete(); e_addr.delete(); e_cyc.delete(); v_bank.delete(); v_cyc.delete();
    done_n = 0; done_cyc = -1; ready_busy = 0; ready_after = -1; sel1 = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = base; cmd_len = len; cmd_mode = mode; cmd_mask = mask;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc == 1) sel1 = int'(output_sel);
      if (enb !== 9'd0) begin
        e_enb.push_back(enb); e_addr.push_back(addrb); e_cyc.push_back(cyc);
      end
      if (rd_valid === 1'b1) begin
        v_bank.push_back(rd_bank); v_cyc.push_back(cyc);
      end
      if (done_n == 0 && cmd_ready === 1'b1) ready_busy++;
      if (cyc == done_cyc + 1 && done_n > 0) ready_after = int'(cmd_ready);
      if (done === 1'b1) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      pause = (cyc >= p_start) && (cyc < p_start + p_len);
      if (done_n > 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end
    pause = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; cmd_mode = 1'b0;
    cmd_mask = '0; pause = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (enb !== 9'd0) begin errors++; $display("FAIL rst_enb got %h exp 000", enb); end
    checks++; if (addrb !== 14'd0) begin errors++; $display("FAIL rst_addrb got %0d exp 0", addrb); end
    checks++; if (output_sel !== 1'b0) begin errors++; $display("FAIL rst_sel got %b exp 0", output_sel); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_bank !== 4'd0) begin errors++; $display("FAIL rst_rd_bank got %0d exp 0", rd_bank); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_parallel;
    run_cmd(14'd100, 14'd4, 1'b1, 9'h1FF, 0, 0);
    checks++; if (e_enb.size() != 4) begin errors++; $display("FAIL par_beats got %0d exp 4", e_enb.size()); end
    for (int i = 0; i < e_enb.size() && i < 4; i++) begin
      checks++;
      if (e_enb[i] !== 9'h1FF || e_addr[i] !== 14'(100 + i) || e_cyc[i] != 2 + i) begin
        errors++;
        $display("FAIL par_beat%0d got enb=%h addr=%0d cyc=%0d exp enb=1ff addr=%0d cyc=%0d",
                 i, e_enb[i], e_addr[i], e_cyc[i], 100 + i, 2 + i);
      end
    end
    checks++; if (v_cyc.size() != 4) begin errors++; $display("FAIL par_valids got %0d exp 4", v_cyc.size()); end
    for (int i = 0; i < v_cyc.size() && i < 4; i++) begin
      checks++;
      if (v_cyc[i] != 4 + i || v_bank[i] !== 4'd0) begin
        errors++;
        $display("FAIL par_valid%0d got cyc=%0d bank=%0d exp cyc=%0d bank=0", i, v_cyc[i], v_bank[i], 4 + i);
      end
    end
    checks++; if (sel1 != 1) begin errors++; $display("FAIL par_sel got %0d exp 1", sel1); end
    checks++; if (done_n != 1 || done_cyc != 8) begin errors++; $display("FAIL par_done got n=%0d cyc=%0d exp n=1 cyc=8", done_n, done_cyc); end
    checks++; if (ready_busy != 0) begin errors++; $display("FAIL par_ready_busy got %0d exp 0", ready_busy); end
    checks++; if (ready_after != 1) begin errors++; $display("FAIL par_ready_after got %0d exp 1", ready_after); end
  endtask

  task automatic test_serial;
    logic [8:0]  xe [6];
    logic [13:0] xa [6];
    int          xb [6];
    xe = '{9'h001, 9'h004, 9'h010, 9'h001, 9'h004, 9'h010};
    xa = '{14'd0, 14'd0, 14'd0, 14'd1, 14'd1, 14'd1};
    xb = '{0, 2, 4, 0, 2, 4};
    run_cmd(14'd0, 14'd2, 1'b0, 9'b000010101, 0, 0);
    checks++; if (e_enb.size() != 6) begin errors++; $display("FAIL ser_beats got %0d exp 6", e_enb.size()); end
    for (int i = 0; i < e_enb.size() && i < 6; i++) begin
      checks++;
      if (e_enb[i] !== xe[i] || e_addr[i] !== xa[i] || e_cyc[i] != 2 + i) begin
        errors++;
        $display("FAIL ser_beat%0d got enb=%h addr=%0d cyc=%0d exp enb=%h addr=%0d cyc=%0d",
                 i, e_enb[i], e_addr[i], e_cyc[i], xe[i], xa[i], 2 + i);
      end
    end
    checks++; if (v_cyc.size() != 6) begin errors++; $display("FAIL ser_valids got %0d exp 6", v_cyc.size()); end
    for (int i = 0; i < v_cyc.size() && i < 6; i++) begin
      checks++;
      if (v_cyc[i] != 4 + i || int'(v_bank[i]) != xb[i]) begin
        errors++;
        $display("FAIL ser_valid%0d got cyc=%0d bank=%0d exp cyc=%0d bank=%0d", i, v_cyc[i], v_bank[i], 4 + i, xb[i]);
      end
    end
    checks++; if (sel1 != 0) begin errors++; $display("FAIL ser_sel got %0d exp 0", sel1); end
    checks++; if (done_n != 1 || done_cyc != 10) begin errors++; $display("FAIL ser_done got n=%0d cyc=%0d exp n=1 cyc=10", done_n, done_cyc); end
  endtask

  task automatic test_wrap;
    logic [13:0] xa [3];
    xa = '{14'd16382, 14'd16383, 14'd0};
    run_cmd(14'd16382, 14'd3, 1'b1, 9'h0F3, 0, 0);
    checks++; if (e_enb.size() != 3) begin errors++; $display("FAIL wrap_beats got %0d exp 3", e_enb.size()); end
    for (int i = 0; i < e_enb.size() && i < 3; i++) begin
      checks++;
      if (e_addr[i] !== xa[i] || e_enb[i] !== 9'h0F3) begin
        errors++;
        $display("FAIL wrap_beat%0d got addr=%0d enb=%h exp addr=%0d enb=0f3", i, e_addr[i], e_enb[i], xa[i]);
      end
    end
    checks++; if (v_cyc.size() != 3) begin errors++; $display("FAIL wrap_valids got %0d exp 3", v_cyc.size()); end
    checks++; if (done_n != 1 || done_cyc != 7) begin errors++; $display("FAIL wrap_done got n=%0d cyc=%0d exp n=1 cyc=7", done_n, done_cyc); end
  endtask

  task automatic test_zero;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) run_cmd(14'd5, 14'd0, 1'b1, 9'h1FF, 0, 0);
      else        run_cmd(14'd5, 14'd5, 1'b0, 9'h000, 0, 0);
      checks++; if (e_enb.size() != 0) begin errors++; $display("FAIL zero%0d_beats got %0d exp 0", t, e_enb.size()); end
      checks++; if (v_cyc.size() != 0) begin errors++; $display("FAIL zero%0d_valids got %0d exp 0", t, v_cyc.size()); end
      checks++; if (done_n != 1 || done_cyc != 1) begin errors++; $display("FAIL zero%0d_done got n=%0d cyc=%0d exp n=1 cyc=1", t, done_n, done_cyc); end
      checks++; if (ready_after != 1) begin errors++; $display("FAIL zero%0d_ready got %0d exp 1", t, ready_after); end
    end
  endtask

  task automatic test_pause;
    int bad;
    run_cmd(14'd50, 14'd3, 1'b0, 9'h1FF, 5, 5);
    checks++; if (e_enb.size() != 27) begin errors++; $display("FAIL pause_beats got %0d exp 27", e_enb.size()); end
    bad = 0;
    for (int j = 0; j < e_enb.size() && j < 27; j++) begin
      if (e_enb[j] !== (9'(1) << (j % 9)) || e_addr[j] !== 14'(50 + j / 9) ||
          e_cyc[j] != ((j < 4) ? 2 + j : 7 + j)) begin
        if (bad == 0)
          $display("FAIL pause_beat%0d got enb=%h addr=%0d cyc=%0d exp enb=%h addr=%0d cyc=%0d", j, e_enb[j],
                   e_addr[j], e_cyc[j], 9'(1) << (j % 9), 50 + j / 9, (j < 4) ? 2 + j : 7 + j);
        bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL pause_seq got %0d bad beats exp 0", bad); end
    checks++; if (v_cyc.size() != 27) begin errors++; $display("FAIL pause_valids got %0d exp 27", v_cyc.size()); end
    checks++; if (done_n != 1 || done_cyc != 36) begin errors++; $display("FAIL pause_done got n=%0d cyc=%0d exp n=1 cyc=36", done_n, done_cyc); end
  endtask

  task automatic test_reset_mid;
    int n_enb, n_val, n_done;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 14'd200; cmd_len = 14'd10; cmd_mode = 1'b1; cmd_mask = 9'h1FF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (enb !== 9'h1FF || addrb !== 14'd200) begin errors++; $display("FAIL rmid_running got enb=%h addr=%0d exp enb=1ff addr=200", enb, addrb); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (enb !== 9'd0 || addrb !== 14'd0 || output_sel !== 1'b0 || rd_valid !== 1'b0 || rd_bank !== 4'd0 ||
        busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_outputs got enb=%h addr=%0d sel=%b vld=%b bank=%0d busy=%b done=%b rdy=%b exp all 0 rdy=1",
               enb, addrb, output_sel, rd_valid, rd_bank, busy, done, cmd_ready);
    end
    n_enb = 0; n_val = 0; n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (enb !== 9'd0) n_enb++;
      if (rd_valid !== 1'b0) n_val++;
      if (done !== 1'b0) n_done++;
    end
    checks++; if (n_enb != 0 || n_val != 0 || n_done != 0) begin errors++; $display("FAIL rmid_quiet got enb=%0d vld=%0d done=%0d exp 0 0 0", n_enb, n_val, n_done); end
    run_cmd(14'd7, 14'd1, 1'b1, 9'h001, 0, 0);
    checks++;
    if (e_enb.size() != 1 || e_addr.size() != 1 || e_addr[0] !== 14'd7 || done_n != 1) begin
      errors++;
      $display("FAIL rmid_new_cmd got beats=%0d done=%0d exp beats=1 addr=7 done=1", e_enb.size(), done_n);
    end
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_serial();
    test_wrap();
    test_zero();
    test_pause();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
